// File: rtl/do_req_pkg.sv
// Shared types and sizing helpers for the do_req_sequencer block.
`default_nettype none

package do_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2,
    GAP    = 2'd3
  } state_e;

  // Counter width large enough to hold the largest of the three phase lengths.
  function automatic int CNT_W(input int hold, input int gap, input int tmo);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/do_req_sequencer_cnt.sv
// cyc_down_cnt: loadable, saturating-at-zero down-counter with a zero flag.
`default_nettype none

module cyc_down_cnt
  import do_req_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/do_req_sequencer.sv
// do_req_sequencer: queues start pulses and paces the do/g handshake.
// Optional ASSERT timeout enabled by defining DO_REQ_TIMEOUT_EN.
`default_nettype none

module do_req_sequencer
  import do_req_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 4,
  parameter int PEND_W      = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              g_i,
  output logic              do_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_cnt_o,
  output logic              overflow_o,
  output logic              timeout_err_o
);

  localparam int CW = CNT_W(HOLD_CYCLES, GAP_CYCLES, TIMEOUT);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ASSERT = ASSERT;
  localparam logic [1:0] S_HOLD   = HOLD;
  localparam logic [1:0] S_GAP    = GAP;

  localparam logic [CW-1:0]     HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic [1:0]        state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              to_err_q, to_err_d;
  logic              do_q;

  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]     cnt_val;

`ifdef DO_REQ_TIMEOUT_EN
  logic to_zero;
  logic to_load;

  // Loaded on every entry into ASSERT so each request gets the full window.
  assign to_load = (state_q != S_ASSERT) && (state_d == S_ASSERT);

  cyc_down_cnt #(.W(CW)) u_to_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (to_load),
    .load_val_i (CW'(TIMEOUT - 1)),
    .dec_i      (state_q == S_ASSERT),
    .zero_o     (to_zero)
  );
`endif

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    to_err_d = to_err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;

    if (abort_i) begin
      pend_d = '0;
      case (state_q)
        S_ASSERT, S_HOLD: begin
          state_d  = S_GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end
        S_GAP:   cnt_dec = 1'b1;
        default: ;
      endcase
    end else begin
      if ((state_q != S_IDLE) && start_i) begin
        if (pend_q == PEND_MAX) ovf_d  = 1'b1;
        else                    pend_d = pend_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          // A start in this cycle is consumed directly, so the count only drops without one.
          if (start_i || (pend_q != '0)) begin
            state_d = S_ASSERT;
            if (!start_i) pend_d = pend_q - 1'b1;
          end
        end
        S_ASSERT: begin
          if (g_i) begin
            state_d  = S_HOLD;
            cnt_load = 1'b1;
            cnt_val  = HOLD_LOAD;
          end
`ifdef DO_REQ_TIMEOUT_EN
          else if (to_zero) begin
            to_err_d = 1'b1;
            state_d  = S_GAP;
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
          end
`endif
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state_d  = S_GAP;
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          if (cnt_zero) state_d = S_IDLE;
          else          cnt_dec = 1'b1;
        end
      endcase
    end
  end

  cyc_down_cnt #(.W(CW)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      to_err_q <= 1'b0;
      do_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      to_err_q <= to_err_d;
      do_q     <= (state_d == S_ASSERT) || (state_d == S_HOLD);
    end
  end

  assign do_o       = do_q;
  assign busy_o     = (state_q != S_IDLE);
  assign pend_cnt_o = pend_q;
  assign overflow_o = ovf_q;

`ifdef DO_REQ_TIMEOUT_EN
  assign timeout_err_o = to_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_do_req_sequencer.sv
// Self-checking bench for do_req_sequencer against a phase-level reference model.
`default_nettype none

module tb_do_req_sequencer;

  localparam int HOLD    = 10;
  localparam int GAP     = 4;
  localparam int PEND_W  = 2;
  localparam int TIMEOUT = 8;
  localparam int PMAX    = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic g_i = 1'b0;
  logic do_o, busy_o, overflow_o, timeout_err_o;
  logic [PEND_W-1:0] pend_cnt_o;
  logic [PEND_W+3:0] obs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: mode 0 idle, 1 waiting for ack, 2 holding, 3 gapping; left = cycles remaining in phase.
  int m_mode = 0, m_left = 0, m_wait = 0, m_pend = 0;
  bit m_ovf = 1'b0, m_to = 1'b0;

  do_req_sequencer #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .PEND_W      (PEND_W),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .g_i           (g_i),
    .do_o          (do_o),
    .busy_o        (busy_o),
    .pend_cnt_o    (pend_cnt_o),
    .overflow_o    (overflow_o),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk = ~clk;

  assign obs = {do_o, busy_o, pend_cnt_o, overflow_o, timeout_err_o};

  function automatic void model_update(input bit s, input bit a, input bit gg, input bit r);
    if (r) begin
      m_mode = 0; m_left = 0; m_wait = 0; m_pend = 0; m_ovf = 0; m_to = 0;
      return;
    end
    if (a) begin
      m_pend = 0;
      if (m_mode == 1 || m_mode == 2) begin
        m_mode = 3; m_left = GAP;
      end else if (m_mode == 3 && m_left > 1) begin
        m_left--;
      end
      return;
    end
    if (m_mode != 0 && s) begin
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend++;
    end
    case (m_mode)
      0: if (s || m_pend > 0) begin
           m_pend = m_pend + int'(s) - 1; m_mode = 1; m_wait = 0;
         end
      1: if (gg) begin
           m_mode = 2; m_left = HOLD;
         end else begin
           m_wait++;
`ifdef DO_REQ_TIMEOUT_EN
           if (m_wait == TIMEOUT) begin
             m_to = 1; m_mode = 3; m_left = GAP;
           end
`endif
         end
      2: if (m_left == 1) begin m_mode = 3; m_left = GAP; end else m_left--;
      default: if (m_left == 1) m_mode = 0; else m_left--;
    endcase
  endfunction

  function automatic logic [PEND_W+3:0] model_vec();
    return {(m_mode == 1 || m_mode == 2), (m_mode != 0), PEND_W'(m_pend), m_ovf, m_to};
  endfunction

  task automatic step(input bit s, input bit a, input bit gg, input bit r);
    start_i = s; abort_i = a; g_i = gg; rst = r;
    @(posedge clk);
    model_update(s, a, gg, r);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, {(PEND_W+4){1'b0}});
    end
    step(0, 0, 0, 0);
    checks++;
    if (obs !== model_vec()) begin
      errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
    end
  endtask

  task automatic test_single();
    int n_hi, n_gap;
    step(1, 0, 0, 0);
    checks++;
    if (do_o !== 1'b1) begin
      errors++; $display("FAIL single_rise cyc=%0d got=%b exp=1", cyc, do_o);
    end
    n_hi = 1; n_gap = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      if (do_o) n_hi++;
      else if (busy_o) n_gap++;
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL single_model cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
      step(0, 0, 0, 0);
    end
    checks++;
    if (n_hi !== 1 + HOLD) begin
      errors++; $display("FAIL single_high cyc=%0d got=%0d exp=%0d", cyc, n_hi, 1 + HOLD);
    end
    checks++;
    if (n_gap !== GAP) begin
      errors++; $display("FAIL single_gap cyc=%0d got=%0d exp=%0d", cyc, n_gap, GAP);
    end
  endtask

  task automatic test_queue();
    int low, rises;
    bit prev, fell;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0, 0);
      checks++;
      if (pend_cnt_o !== PEND_W'(k)) begin
        errors++; $display("FAIL queue_pend cyc=%0d got=%0d exp=%0d", cyc, pend_cnt_o, k);
      end
    end
    prev = 1'b1; fell = 1'b0; low = 0; rises = 0;
    for (int i = 0; i < 80; i++) begin
      step(0, 0, do_o, 0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL queue_model cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
      if (!do_o) begin
        low++; fell = 1'b1;
      end else if (!prev && fell) begin
        rises++;
        checks++;
        if (low !== GAP + 1) begin
          errors++; $display("FAIL queue_lowgap cyc=%0d got=%0d exp=%0d", cyc, low, GAP + 1);
        end
        low = 0;
      end
      prev = do_o;
    end
    checks++;
    if (rises !== 3 || busy_o !== 1'b0 || pend_cnt_o !== '0) begin
      errors++; $display("FAIL queue_drain cyc=%0d got=%0d/%b/%0d exp=3/0/0", cyc, rises, busy_o, pend_cnt_o);
    end
  endtask

  task automatic test_overflow();
    int ep;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 0, 0);
      ep = (k > PMAX) ? PMAX : k;
      checks++;
      if (pend_cnt_o !== PEND_W'(ep) || overflow_o !== (k > PMAX)) begin
        errors++; $display("FAIL ovf_sat cyc=%0d got=%0d/%b exp=%0d/%b", cyc, pend_cnt_o, overflow_o, ep, k > PMAX);
      end
    end
    for (int i = 0; i < 80; i++) begin
      step(0, 0, do_o, 0);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL ovf_model cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
    end
    checks++;
    if (overflow_o !== 1'b1 || pend_cnt_o !== '0) begin
      errors++; $display("FAIL ovf_sticky cyc=%0d got=%b/%0d exp=1/0", cyc, overflow_o, pend_cnt_o);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++; $display("FAIL ovf_clear cyc=%0d got=%b exp=0", cyc, overflow_o);
    end
  endtask

  task automatic test_abort();
    int n_gap;
    bit rose;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    checks++;
    if (do_o !== 1'b0 || pend_cnt_o !== '0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL abort_hold cyc=%0d got=%b/%0d/%b exp=0/0/1", cyc, do_o, pend_cnt_o, busy_o);
    end
    n_gap = 1; rose = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      if (busy_o) n_gap++;
      if (do_o) rose = 1'b1;
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL abort_model cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
    end
    checks++;
    if (n_gap !== GAP || rose !== 1'b0) begin
      errors++; $display("FAIL abort_gap cyc=%0d got=%0d/%b exp=%0d/0", cyc, n_gap, rose, GAP);
    end
  endtask

  task automatic test_timeout();
    int n_hi, exp_hi;
    bit fell, exp_to;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_hi = 2; fell = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step(0, 0, 0, 0);
      if (!do_o) fell = 1'b1;
      else if (!fell) n_hi++;
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL timeout_model cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
    end
`ifdef DO_REQ_TIMEOUT_EN
    exp_hi = TIMEOUT; exp_to = 1'b1;
`else
    exp_hi = 24; exp_to = 1'b0;
`endif
    checks++;
    if (n_hi !== exp_hi || timeout_err_o !== exp_to) begin
      errors++; $display("FAIL timeout_len cyc=%0d got=%0d/%b exp=%0d/%b", cyc, n_hi, timeout_err_o, exp_hi, exp_to);
    end
    step(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  task automatic test_rst_mid();
    bit rose;
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
    checks++;
    if (pend_cnt_o !== PEND_W'(3) || do_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_setup cyc=%0d got=%0d/%b exp=3/1", cyc, pend_cnt_o, do_o);
    end
    step(0, 0, 0, 1);
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL rstmid_clear cyc=%0d got=%b exp=0", cyc, obs);
    end
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      if (do_o) rose = 1'b1;
    end
    checks++;
    if (rose !== 1'b0) begin
      errors++; $display("FAIL rstmid_noissue cyc=%0d got=%b exp=0", cyc, rose);
    end
    step(1, 0, 0, 0);
    checks++;
    if (do_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart cyc=%0d got=%b exp=1", cyc, do_o);
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_random();
    bit s, a, gg, r;
    for (int i = 0; i < 1500; i++) begin
      s  = ($urandom_range(0, 99) < 25);
      a  = ($urandom_range(0, 99) < 3);
      gg = ($urandom_range(0, 99) < 30);
      r  = ($urandom_range(0, 999) < 5);
      step(s, a, gg, r);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_abort();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
